// File: rtl/lsu_mem_master_pkg.sv
// Shared types and constants for the load/store memory master.
// Data memory depth and RV32I load/store funct3 codes live here.
package lsu_mem_master_pkg;

    localparam int unsigned ADDR_W_DEF   = 32;
    localparam int unsigned DCATCH_DEPTH = 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC,
        S_RDW,
        S_ERR,
        S_SPL2,
        S_RDW2
    } state_t;

    // Stores only have SB/SH/SW; loads additionally have LBU/LHU.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        if (we)
            return f3[2] | (f3[1:0] == 2'b11);
        else
            return (f3 == 3'b011) | (f3[2:1] == 2'b11);
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b01:   return off[0];
            2'b10:   return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// Request/response and byte-lane memory bus of the load/store master.
interface lsu_mem_master_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_wren;
    logic [31:0]       mem_wrdata;
    logic [3:0]        mem_rden;
    logic [31:0]       mem_rddata;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rddata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_addr, mem_wren, mem_wrdata, mem_rden
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rddata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_addr, mem_wren, mem_wrdata, mem_rden
    );

endinterface

// File: rtl/lsu_mem_master_load_fmt.sv
// Load result formatter: byte/half/word select from a (possibly merged 64-bit)
// read word, then sign or zero extension. Purely combinational.
module lsu_load_fmt
    import lsu_mem_master_pkg::*;
(
    input  logic [63:0] i_rddata,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_rdata
);

    logic [31:0] w_sh;

    assign w_sh = 32'(i_rddata >> {i_offset, 3'b000});

    always_comb begin
        o_rdata = '0;
        case (i_funct3)
            F3_B:    o_rdata = {{24{w_sh[7]}}, w_sh[7:0]};
            F3_H:    o_rdata = {{16{w_sh[15]}}, w_sh[15:0]};
            F3_W:    o_rdata = w_sh;
            F3_BU:   o_rdata = {24'h0, w_sh[7:0]};
            F3_HU:   o_rdata = {16'h0, w_sh[15:0]};
            default: o_rdata = '0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// RV32 load/store initiator onto a byte-lane data memory.
// Define LSU_MISALIGN_SPLIT_EN to split word-crossing accesses into two words.
module lsu_mem_master
    import lsu_mem_master_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DEPTH  = DCATCH_DEPTH
) (
    input logic              clk,
    input logic              rst,
    lsu_mem_master_if.master bus
);

    if (DEPTH < 3 || DEPTH > ADDR_W) begin : g_bad_depth
        $error("lsu_mem_master: DEPTH out of range");
    end

    state_t            r_state;
    logic              r_ready;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [3:0]        r_wren;
    logic [3:0]        r_rden;
    logic [31:0]       r_wrdata;
    logic              r_we;
    logic              r_split;
    logic [2:0]        r_f3;
    logic [1:0]        r_off;

    logic [1:0]        w_off;
    logic [3:0]        w_base;
    logic [3:0]        w_mask;
    logic [31:0]       w_wr_lo;
    logic              w_misal;
    logic              w_illegal;
    logic              w_err;
    logic              w_split;
    logic [ADDR_W-1:0] w_word_addr;
    logic [63:0]       w_fmt_in;
    logic [31:0]       w_fmt_out;
    logic              w_rsp_en;

`ifdef LSU_MISALIGN_SPLIT_EN
    logic [7:0]        w_mask8;
    logic [31:0]       w_wdata_sz;
    logic [63:0]       w_wr64;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_mask_hi;
    logic [31:0]       r_wr_hi;
    logic [31:0]       r_lo;
`endif

    assign w_off       = bus.req_addr[1:0];
    assign w_word_addr = {bus.req_addr[ADDR_W-1:2], 2'b00};
    assign w_misal     = f3_misaligned(bus.req_funct3, w_off);
    assign w_illegal   = f3_illegal(bus.req_we, bus.req_funct3);

    always_comb begin
        w_base = 4'b1111;
        case (bus.req_funct3[1:0])
            2'b00:   w_base = 4'b0001;
            2'b01:   w_base = 4'b0011;
            default: w_base = 4'b1111;
        endcase
    end

`ifdef LSU_MISALIGN_SPLIT_EN
    // Lanes past byte 3 belong to the following word.
    assign w_mask8    = {4'b0000, w_base} << w_off;
    assign w_mask     = w_mask8[3:0];
    assign w_split    = |w_mask8[7:4];
    assign w_err      = w_illegal;
    assign w_wdata_sz = bus.req_funct3[0] ? {16'h0, bus.req_wdata[15:0]} : bus.req_wdata;
    assign w_wr64     = {32'h0, w_wdata_sz} << {w_off, 3'b000};
`else
    assign w_mask  = w_base << w_off;
    assign w_split = 1'b0;
    assign w_err   = w_illegal | w_misal;
`endif

    always_comb begin
        w_wr_lo = bus.req_wdata;
        case (bus.req_funct3[1:0])
            2'b00:   w_wr_lo = {4{bus.req_wdata[7:0]}};
            2'b01:   w_wr_lo = {2{bus.req_wdata[15:0]}};
            default: w_wr_lo = bus.req_wdata;
        endcase
`ifdef LSU_MISALIGN_SPLIT_EN
        if (w_misal) w_wr_lo = w_wr64[31:0];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ready     <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_mem_addr  <= '0;
            r_wren      <= '0;
            r_rden      <= '0;
            r_wrdata    <= '0;
            r_we        <= 1'b0;
            r_split     <= 1'b0;
            r_f3        <= '0;
            r_off       <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            r_addr      <= '0;
            r_mask_hi   <= '0;
            r_wr_hi     <= '0;
            r_lo        <= '0;
`endif
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_mem_addr  <= '0;
            r_wren      <= '0;
            r_rden      <= '0;
            r_wrdata    <= '0;
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_ready <= 1'b0;
                        r_we    <= bus.req_we;
                        r_f3    <= bus.req_funct3;
                        r_off   <= w_off;
                        r_split <= w_split;
`ifdef LSU_MISALIGN_SPLIT_EN
                        r_addr    <= w_word_addr;
                        r_mask_hi <= w_mask8[7:4];
                        r_wr_hi   <= w_wr64[63:32];
`endif
                        if (w_err) begin
                            r_state     <= S_ERR;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                        end else begin
                            r_state    <= S_ACC;
                            r_mem_addr <= w_word_addr;
                            if (bus.req_we) begin
                                r_wren      <= w_mask;
                                r_wrdata    <= w_wr_lo;
                                r_rsp_valid <= ~w_split;
                            end else begin
                                r_rden <= w_mask;
                            end
                        end
                    end
                end
                S_ACC: begin
                    if (!r_we) begin
                        r_state     <= S_RDW;
                        r_rsp_valid <= ~r_split;
                    end else if (r_split) begin
                        r_state     <= S_SPL2;
                        r_rsp_valid <= 1'b1;
`ifdef LSU_MISALIGN_SPLIT_EN
                        r_mem_addr  <= r_addr + ADDR_W'(4);
                        r_wren      <= r_mask_hi;
                        r_wrdata    <= r_wr_hi;
`endif
                    end else begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                    end
                end
                S_RDW: begin
                    if (r_split) begin
                        r_state    <= S_SPL2;
`ifdef LSU_MISALIGN_SPLIT_EN
                        r_lo       <= bus.mem_rddata;
                        r_mem_addr <= r_addr + ADDR_W'(4);
                        r_rden     <= r_mask_hi;
`endif
                    end else begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                    end
                end
                S_SPL2: begin
                    if (r_we) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                    end else begin
                        r_state     <= S_RDW2;
                        r_rsp_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    // Read data is only valid in the cycle after mem_rden, so the load
    // result is formatted straight from mem_rddata during the response cycle.
`ifdef LSU_MISALIGN_SPLIT_EN
    assign w_fmt_in = (r_state == S_RDW2) ? {bus.mem_rddata, r_lo} : {32'h0, bus.mem_rddata};
`else
    assign w_fmt_in = {32'h0, bus.mem_rddata};
`endif
    assign w_rsp_en = ((r_state == S_RDW) && !r_split) || (r_state == S_RDW2);

    lsu_load_fmt u_fmt (
        .i_rddata (w_fmt_in),
        .i_offset (r_off),
        .i_funct3 (r_f3),
        .o_rdata  (w_fmt_out)
    );

    assign bus.req_ready  = r_ready;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_err    = r_rsp_err;
    assign bus.rsp_rdata  = w_rsp_en ? w_fmt_out : '0;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wren   = r_wren;
    assign bus.mem_wrdata = r_wrdata;
    assign bus.mem_rden   = r_rden;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master with a byte-lane synchronous-read memory.
module tb_lsu_mem_master;
    import lsu_mem_master_pkg::*;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    exp_t        sb[$];
    logic [31:0] mem [0:63];

    lsu_mem_master_if #(.ADDR_W(32)) bus ();

    lsu_mem_master #(.ADDR_W(32), .DEPTH(DCATCH_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Lanes that are not read return garbage so leaks into rsp_rdata show up.
    always @(posedge clk) begin : memory
        logic [DCATCH_DEPTH-3:0] idx;
        idx = bus.mem_addr[DCATCH_DEPTH-1:2];
        for (int b = 0; b < 4; b++) begin
            if (bus.mem_wren[b]) mem[idx][8*b +: 8] <= bus.mem_wrdata[8*b +: 8];
            bus.mem_rddata[8*b +: 8] <= bus.mem_rden[b] ? mem[idx][8*b +: 8] : 8'($urandom);
        end
    end

    task automatic monitor();
        logic prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) begin
                n_checks++;
                if (prev) begin
                    n_fail++;
                    $display("FAIL rsp_pulse: rsp_valid high in consecutive cycles at cycle %0d, required single-cycle pulse", cyc);
                end else if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL rsp_unexpected: rsp_valid=1 rdata=%h err=%b at cycle %0d, required no response", bus.rsp_rdata, bus.rsp_err, cyc);
                end else begin
                    e = sb.pop_front();
                    if (bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err || cyc !== e.due) begin
                        n_fail++;
                        $display("FAIL rsp: rdata=%h err=%b cycle=%0d, required rdata=%h err=%b cycle=%0d", bus.rsp_rdata, bus.rsp_err, cyc, e.rdata, e.err, e.due);
                    end
                end
            end
            prev = (bus.rsp_valid === 1'b1);
        end
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err,
                         input int unsigned lat, input bit push);
        bit got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (bus.req_ready === 1'b1) got = 1'b1;
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_timeout: req_ready=%b, required 1 within 50 cycles", bus.req_ready);
            return;
        end
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        if (push) sb.push_back('{exp_rd, exp_err, cyc + lat});
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 ||
            bus.rsp_rdata !== 32'h0 || bus.mem_wren !== 4'h0 || bus.mem_rden !== 4'h0 ||
            bus.mem_addr !== 32'h0 || bus.mem_wrdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: ready=%b rsp_valid=%b err=%b rdata=%h wren=%b rden=%b addr=%h wrdata=%h, required ready=1 rest 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.mem_wren, bus.mem_rden, bus.mem_addr, bus.mem_wrdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_store();
        issue(1'b1, F3_B, 32'h13, 32'h0000_00AB, 32'h0, 1'b0, 1, 1'b1);
        n_checks++;
        if (bus.mem_wren !== 4'b1000 || bus.mem_wrdata !== 32'hABAB_ABAB || bus.mem_addr !== 32'h10 || bus.mem_rden !== 4'h0) begin
            n_fail++;
            $display("FAIL sb_lanes: wren=%b wrdata=%h addr=%h rden=%b, required 1000 abababab 00000010 0000",
                     bus.mem_wren, bus.mem_wrdata, bus.mem_addr, bus.mem_rden);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.mem_wren !== 4'h0 || bus.mem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL sb_after_acc: wren=%b addr=%h, required 0000 00000000", bus.mem_wren, bus.mem_addr);
        end
        drain();
    endtask

    task automatic test_load();
        logic [2:0]  f3s  [6] = '{F3_B, F3_BU, F3_H, F3_W, F3_HU, F3_H};
        logic [31:0] adrs [6] = '{32'h12, 32'h12, 32'h12, 32'h10, 32'h12, 32'h10};
        logic [31:0] exps [6] = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_80FF, 32'h80FF_7F01, 32'h0000_80FF, 32'h0000_7F01};
        logic [3:0]  msks [6] = '{4'b0100, 4'b0100, 4'b1100, 4'b1111, 4'b1100, 4'b0011};
        issue(1'b1, F3_W, 32'h10, 32'h80FF_7F01, 32'h0, 1'b0, 1, 1'b1);
        n_checks++;
        if (bus.mem_wren !== 4'b1111 || bus.mem_wrdata !== 32'h80FF_7F01) begin
            n_fail++;
            $display("FAIL sw_lanes: wren=%b wrdata=%h, required 1111 80ff7f01", bus.mem_wren, bus.mem_wrdata);
        end
        for (int i = 0; i < 6; i++) begin
            issue(1'b0, f3s[i], adrs[i], 32'h0, exps[i], 1'b0, 2, 1'b1);
            n_checks++;
            if (bus.mem_rden !== msks[i] || bus.mem_addr !== 32'h10 || bus.mem_wren !== 4'h0) begin
                n_fail++;
                $display("FAIL load_rden[%0d]: rden=%b addr=%h wren=%b, required %b 00000010 0000",
                         i, bus.mem_rden, bus.mem_addr, bus.mem_wren, msks[i]);
            end
        end
        drain();
    endtask

    task automatic test_errors();
`ifdef LSU_MISALIGN_SPLIT_EN
        localparam int N = 3;
        logic        wes  [N] = '{1'b0, 1'b1, 1'b0};
        logic [2:0]  f3s  [N] = '{3'b011, 3'b100, 3'b111};
        logic [31:0] adrs [N] = '{32'h10, 32'h10, 32'h14};
`else
        localparam int N = 5;
        logic        wes  [N] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [2:0]  f3s  [N] = '{F3_W, 3'b011, 3'b100, F3_H, 3'b111};
        logic [31:0] adrs [N] = '{32'h11, 32'h10, 32'h10, 32'h13, 32'h14};
`endif
        for (int i = 0; i < N; i++) begin
            issue(wes[i], f3s[i], adrs[i], 32'hDEAD_BEEF, 32'h0, 1'b1, 1, 1'b1);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (bus.mem_wren !== 4'h0 || bus.mem_rden !== 4'h0) begin
                    n_fail++;
                    $display("FAIL err_no_access[%0d.%0d]: wren=%b rden=%b, required 0000 0000", i, k, bus.mem_wren, bus.mem_rden);
                end
                @(posedge clk);
                #1;
            end
        end
        drain();
    endtask

    task automatic test_rst_mid_load();
        issue(1'b0, F3_W, 32'h10, 32'h0, 32'h0, 1'b0, 2, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.rsp_valid !== 1'b0 || bus.mem_rden !== 4'h0 || bus.req_ready !== 1'b1 || bus.rsp_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_mid_load: rsp_valid=%b rden=%b ready=%b rdata=%h, required 0 0000 1 00000000",
                     bus.rsp_valid, bus.mem_rden, bus.req_ready, bus.rsp_rdata);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_release_ready: ready=%b, required 1", bus.req_ready);
        end
        issue(1'b0, F3_W, 32'h10, 32'h0, 32'h80FF_7F01, 1'b0, 2, 1'b1);
        drain();
    endtask

    task automatic test_back_to_back();
        logic [2:0]  f3s  [3] = '{F3_W, F3_H, F3_B};
        logic [31:0] adrs [3] = '{32'h20, 32'h26, 32'h29};
        logic [31:0] wds  [3] = '{32'hA5A5_0001, 32'h0000_BEEF, 32'h0000_005A};
        logic [3:0]  wens [3] = '{4'b1111, 4'b1100, 4'b0010};
        logic [31:0] wrd  [3] = '{32'hA5A5_0001, 32'hBEEF_BEEF, 32'h5A5A_5A5A};
        int unsigned acc  [3];
        int k = 0;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = f3s[0];
        bus.req_addr   = adrs[0];
        bus.req_wdata  = wds[0];
        for (int n = 0; n < 20 && k < 3; n++) begin
            if (n != 0) @(negedge clk);
            if (bus.req_ready === 1'b1) begin
                sb.push_back('{32'h0, 1'b0, cyc + 1});
                acc[k] = cyc;
                @(posedge clk);
                #1;
                n_checks++;
                if (bus.mem_wren !== wens[k] || bus.mem_wrdata !== wrd[k] || bus.mem_addr !== (adrs[k] & 32'hFFFF_FFFC)) begin
                    n_fail++;
                    $display("FAIL b2b_store[%0d]: wren=%b wrdata=%h addr=%h, required %b %h %h",
                             k, bus.mem_wren, bus.mem_wrdata, bus.mem_addr, wens[k], wrd[k], adrs[k] & 32'hFFFF_FFFC);
                end
                k++;
                if (k < 3) begin
                    bus.req_funct3 = f3s[k];
                    bus.req_addr   = adrs[k];
                    bus.req_wdata  = wds[k];
                end else begin
                    bus.req_valid = 1'b0;
                end
            end
        end
        bus.req_valid = 1'b0;
        n_checks++;
        if (k != 3 || acc[1] - acc[0] != 2 || acc[2] - acc[1] != 2) begin
            n_fail++;
            $display("FAIL b2b_accept: accepts=%0d gaps=%0d,%0d, required 3 accepts with gaps 2,2",
                     k, acc[1] - acc[0], acc[2] - acc[1]);
        end
        drain();
        issue(1'b0, F3_W,  32'h20, 32'h0, 32'hA5A5_0001, 1'b0, 2, 1'b1);
        issue(1'b0, F3_HU, 32'h26, 32'h0, 32'h0000_BEEF, 1'b0, 2, 1'b1);
        issue(1'b0, F3_B,  32'h29, 32'h0, 32'h0000_005A, 1'b0, 2, 1'b1);
        drain();
    endtask

`ifdef LSU_MISALIGN_SPLIT_EN
    task automatic test_split();
        issue(1'b1, F3_W, 32'h0E, 32'h1122_3344, 32'h0, 1'b0, 2, 1'b1);
        n_checks++;
        if (bus.mem_addr !== 32'h0C || bus.mem_wren !== 4'b1100 || bus.mem_wrdata[31:16] !== 16'h3344) begin
            n_fail++;
            $display("FAIL split_sw_lo: addr=%h wren=%b wrdata=%h, required 0000000c 1100 3344xxxx", bus.mem_addr, bus.mem_wren, bus.mem_wrdata);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.mem_addr !== 32'h10 || bus.mem_wren !== 4'b0011 || bus.mem_wrdata[15:0] !== 16'h1122) begin
            n_fail++;
            $display("FAIL split_sw_hi: addr=%h wren=%b wrdata=%h, required 00000010 0011 xxxx1122", bus.mem_addr, bus.mem_wren, bus.mem_wrdata);
        end
        drain();
        issue(1'b0, F3_W, 32'h0E, 32'h0, 32'h1122_3344, 1'b0, 4, 1'b1);
        n_checks++;
        if (bus.mem_addr !== 32'h0C || bus.mem_rden !== 4'b1100) begin
            n_fail++;
            $display("FAIL split_lw_lo: addr=%h rden=%b, required 0000000c 1100", bus.mem_addr, bus.mem_rden);
        end
        drain();
        issue(1'b0, F3_H, 32'h0F, 32'h0, 32'h0000_2233, 1'b0, 4, 1'b1);
        drain();
    endtask
`endif

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        fork
            monitor();
        join_none
        test_reset();
        test_store();
        test_load();
        test_errors();
        test_rst_mid_load();
        test_back_to_back();
`ifdef LSU_MISALIGN_SPLIT_EN
        test_split();
`endif
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
